// File: rtl/main_i2c_hub.sv
// main_i2c_hub
// Host-bus-to-I2C bridge with four independent I2C master channels.
// Each channel has a 4-byte window starting at BASE_ADR + 4*k:
//   +0 W: CMD {addr[6:0], R/W} (starts a transaction when idle)
//   +0 R: STATUS {busy, nack, 6'b0}
//   +1  : REG pointer byte (R/W)
//   +2  : WDATA (R/W)
//   +3 R: RDATA (0x00 when read support is compiled out)
// Ports:
//   CLK, RES          system clock, synchronous active-high reset
//   ADR, Data         host address and bidirectional data bus
//   BWR, BRD          active-low host write / read strobes
//   SDA_OUT1..4       open-drain SDA (drives 0 or Z)
//   SCL_OUT1..4       push-pull SCL, idle high
// Build option: define MAIN_I2C_READ_EN to enable read transactions and
// the RDATA register; otherwise the R/W bit is forced to 0 on the bus.
//
// Channel FSM
//   state   | meaning
//   S_IDLE  | bus released, waiting for a CMD write
//   S_START | quarter 0: SDA falls, quarter 1: SCL falls
//   S_BIT   | one bit per 4 quarters (q0 drive SDA, q1 SCL rise+sample, q3 SCL fall)
//   S_STOP  | q0 SDA low, q1 SCL rise, q2 SDA release, q3 busy clear
module main_i2c_hub #(
    parameter int         CLK_DIV  = 125,
    parameter logic [9:0] BASE_ADR = 10'h050
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic [9:0] ADR,
    inout  wire  [7:0] Data,
    input  logic       BWR,
    input  logic       BRD,
    inout  wire        SDA_OUT1,
    inout  wire        SDA_OUT2,
    inout  wire        SDA_OUT3,
    inout  wire        SDA_OUT4,
    output logic       SCL_OUT1,
    output logic       SCL_OUT2,
    output logic       SCL_OUT3,
    output logic       SCL_OUT4
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TMR_LD = TW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

    logic [2:0]    bwr_sync_q;
    logic [9:0]    off;
    logic          hit;
    logic [1:0]    ch_sel;
    logic [1:0]    reg_sel;
    logic          wr_stb;
    logic          cmd_rw;
    logic [3:0]    sda_in;
    logic [7:0]    rd_mux;

    state_t        state_q  [4];
    logic [1:0]    qtr_q    [4];
    logic [TW-1:0] tmr_q    [4];
    logic [3:0]    bit_q    [4];
    logic [1:0]    byte_q   [4];
    logic [7:0]    shift_q  [4];
    logic [7:0]    sh_reg_q [4];
    logic [7:0]    sh_wd_q  [4];
    logic [7:0]    reg_q    [4];
    logic [7:0]    wdata_q  [4];
    logic [3:0]    rw_q;
    logic [3:0]    busy_q;
    logic [3:0]    nack_q;
    logic [3:0]    scl_q;
    logic [3:0]    sda_low_q;
`ifdef MAIN_I2C_READ_EN
    logic [7:0]    rdata_q  [4];
    assign cmd_rw = Data[0];
`else
    assign cmd_rw = 1'b0;
`endif

    assign off     = ADR - BASE_ADR;
    assign hit     = (ADR >= BASE_ADR) && (off < 10'd16);
    assign ch_sel  = off[3:2];
    assign reg_sel = off[1:0];
    assign wr_stb  = bwr_sync_q[1] & ~bwr_sync_q[2];

    // A Z line reads as 1 through the external pull-up.
    assign sda_in = {SDA_OUT4, SDA_OUT3, SDA_OUT2, SDA_OUT1};

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            2'd0:    rd_mux = {busy_q[ch_sel], nack_q[ch_sel], 6'b0};
            2'd1:    rd_mux = reg_q[ch_sel];
            2'd2:    rd_mux = wdata_q[ch_sel];
            default: begin
`ifdef MAIN_I2C_READ_EN
                rd_mux = rdata_q[ch_sel];
`else
                rd_mux = 8'h00;
`endif
            end
        endcase
    end

    assign Data = (!BRD && hit) ? rd_mux : 8'hzz;

    assign SCL_OUT1 = scl_q[0];
    assign SCL_OUT2 = scl_q[1];
    assign SCL_OUT3 = scl_q[2];
    assign SCL_OUT4 = scl_q[3];
    assign SDA_OUT1 = sda_low_q[0] ? 1'b0 : 1'bz;
    assign SDA_OUT2 = sda_low_q[1] ? 1'b0 : 1'bz;
    assign SDA_OUT3 = sda_low_q[2] ? 1'b0 : 1'bz;
    assign SDA_OUT4 = sda_low_q[3] ? 1'b0 : 1'bz;

    always_ff @(posedge CLK) begin
        if (RES) begin
            // Preset to the idle-high strobe level so leaving reset is not a write edge.
            bwr_sync_q <= 3'b111;
            rw_q       <= '0;
            busy_q     <= '0;
            nack_q     <= '0;
            scl_q      <= '1;
            sda_low_q  <= '0;
            for (int c = 0; c < 4; c++) begin
                state_q[c]  <= S_IDLE;
                qtr_q[c]    <= '0;
                tmr_q[c]    <= '0;
                bit_q[c]    <= '0;
                byte_q[c]   <= '0;
                shift_q[c]  <= '0;
                sh_reg_q[c] <= '0;
                sh_wd_q[c]  <= '0;
                reg_q[c]    <= '0;
                wdata_q[c]  <= '0;
`ifdef MAIN_I2C_READ_EN
                rdata_q[c]  <= '0;
`endif
            end
        end else begin
            bwr_sync_q <= {bwr_sync_q[1:0], BWR};
            for (int c = 0; c < 4; c++) begin
                if (wr_stb && hit && ch_sel == 2'(c)) begin
                    if (reg_sel == 2'd1) reg_q[c]   <= Data;
                    if (reg_sel == 2'd2) wdata_q[c] <= Data;
                end
                if (state_q[c] != S_IDLE) begin
                    if (tmr_q[c] != '0) tmr_q[c] <= tmr_q[c] - 1'b1;
                    else                tmr_q[c] <= TMR_LD;
                end
                case (state_q[c])
                    S_IDLE: begin
                        // Only an idle channel accepts CMD; busy is the registered value.
                        if (wr_stb && hit && ch_sel == 2'(c) && reg_sel == 2'd0) begin
                            state_q[c]  <= S_START;
                            busy_q[c]   <= 1'b1;
                            nack_q[c]   <= 1'b0;
                            qtr_q[c]    <= '0;
                            tmr_q[c]    <= TMR_LD;
                            rw_q[c]     <= cmd_rw;
                            shift_q[c]  <= {Data[7:1], cmd_rw};
                            sh_reg_q[c] <= reg_q[c];
                            sh_wd_q[c]  <= wdata_q[c];
                        end
                    end
                    S_START: begin
                        if (tmr_q[c] == '0) begin
                            if (qtr_q[c] == 2'd0) begin
                                sda_low_q[c] <= 1'b1;
                                qtr_q[c]     <= 2'd1;
                            end else begin
                                scl_q[c]   <= 1'b0;
                                state_q[c] <= S_BIT;
                                qtr_q[c]   <= '0;
                                bit_q[c]   <= '0;
                                byte_q[c]  <= '0;
                            end
                        end
                    end
                    S_BIT: begin
                        if (tmr_q[c] == '0) begin
                            qtr_q[c] <= qtr_q[c] + 2'd1;
                            case (qtr_q[c])
                                2'd0: begin
                                    // Release for the slave ACK slot, for read data, and for the master NACK.
                                    if (bit_q[c] == 4'd8 || (rw_q[c] && byte_q[c] == 2'd1))
                                        sda_low_q[c] <= 1'b0;
                                    else
                                        sda_low_q[c] <= ~shift_q[c][7];
                                end
                                2'd1: begin
                                    scl_q[c] <= 1'b1;
                                    if (bit_q[c] != 4'd8)
                                        shift_q[c] <= {shift_q[c][6:0], sda_in[c]};
                                    else if (!(rw_q[c] && byte_q[c] == 2'd1) && sda_in[c])
                                        nack_q[c] <= 1'b1;
                                end
                                2'd3: begin
                                    scl_q[c] <= 1'b0;
                                    if (bit_q[c] != 4'd8) begin
                                        bit_q[c] <= bit_q[c] + 4'd1;
                                    end else if (nack_q[c] || byte_q[c] == (rw_q[c] ? 2'd1 : 2'd2)) begin
                                        state_q[c] <= S_STOP;
`ifdef MAIN_I2C_READ_EN
                                        if (rw_q[c] && !nack_q[c]) rdata_q[c] <= shift_q[c];
`endif
                                    end else begin
                                        bit_q[c]   <= '0;
                                        byte_q[c]  <= byte_q[c] + 2'd1;
                                        shift_q[c] <= (byte_q[c] == 2'd0) ? sh_reg_q[c] : sh_wd_q[c];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_STOP: begin
                        if (tmr_q[c] == '0) begin
                            qtr_q[c] <= qtr_q[c] + 2'd1;
                            case (qtr_q[c])
                                2'd0: sda_low_q[c] <= 1'b1;
                                2'd1: scl_q[c]     <= 1'b1;
                                2'd2: sda_low_q[c] <= 1'b0;
                                default: begin
                                    busy_q[c]  <= 1'b0;
                                    state_q[c] <= S_IDLE;
                                end
                            endcase
                        end
                    end
                    default: state_q[c] <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_main_i2c_hub.sv
module tb_main_i2c_hub;
    localparam int         CLK_DIV = 2;
    localparam logic [9:0] BASE    = 10'h050;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [9:0] adr = '0;
    logic       bwr = 1'b1;
    logic       brd = 1'b1;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = '0;
    logic [3:0] slv_low = '0;
    wire  [7:0] data;
    wire        sda1, sda2, sda3, sda4;
    logic       scl1, scl2, scl3, scl4;

    assign data = drv_en ? drv_val : 8'hzz;
    assign sda1 = slv_low[0] ? 1'b0 : 1'bz;
    assign sda2 = slv_low[1] ? 1'b0 : 1'bz;
    assign sda3 = slv_low[2] ? 1'b0 : 1'bz;
    assign sda4 = slv_low[3] ? 1'b0 : 1'bz;
    pullup (sda1);
    pullup (sda2);
    pullup (sda3);
    pullup (sda4);
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    always #5 clk = ~clk;

    main_i2c_hub #(.CLK_DIV(CLK_DIV), .BASE_ADR(BASE)) dut (
        .CLK(clk), .RES(res), .ADR(adr), .Data(data), .BWR(bwr), .BRD(brd),
        .SDA_OUT1(sda1), .SDA_OUT2(sda2), .SDA_OUT3(sda3), .SDA_OUT4(sda4),
        .SCL_OUT1(scl1), .SCL_OUT2(scl2), .SCL_OUT3(scl3), .SCL_OUT4(scl4)
    );

    wire [3:0] scl_v = {scl4, scl3, scl2, scl1};
    wire [3:0] sda_v = {sda4, sda3, sda2, sda1};

    int tests = 0;
    int fails = 0;

    // Slave model / bus monitor: one I2C slave per channel, bit-counting from START.
    int         nbits  [4];
    int         pulses [4];
    int         starts [4];
    int         stops  [4];
    int         rises  [4];
    int         cap_n  [4];
    logic [7:0] cap_mem [4][64];
    logic [7:0] shreg  [4];
    logic [3:0] rd_mode  = '0;
    logic [3:0] last_ack = '0;
    logic [3:0] pscl = 4'hF;
    logic [3:0] psda = 4'hF;
    logic [3:0] ack_mask [4];
    logic [7:0] rd_val   [4];
    int         pos, byt;

    initial begin
        for (int c = 0; c < 4; c++) begin
            nbits[c] = 0; pulses[c] = 0; starts[c] = 0; stops[c] = 0;
            rises[c] = 0; cap_n[c] = 0; shreg[c] = '0;
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (scl_v[c] && pscl[c] && psda[c] && !sda_v[c]) begin
                starts[c]++;
                nbits[c] = 0;
                rd_mode[c] = 1'b0;
            end else if (scl_v[c] && pscl[c] && !psda[c] && sda_v[c]) begin
                stops[c]++;
            end
            if (scl_v[c] && !pscl[c]) begin
                rises[c]++;
                if (nbits[c] % 9 == 8) begin
                    last_ack[c] = sda_v[c];
                end else begin
                    shreg[c] = {shreg[c][6:0], sda_v[c]};
                    if (nbits[c] % 9 == 7) begin
                        cap_mem[c][cap_n[c] % 64] = shreg[c];
                        cap_n[c]++;
                        if (nbits[c] == 7) rd_mode[c] = shreg[c][0];
                    end
                end
                nbits[c]++;
            end
            if (!scl_v[c] && pscl[c]) begin
                if (nbits[c] > 0) pulses[c]++;
                pos = nbits[c] % 9;
                byt = nbits[c] / 9;
                if (pos == 8)
                    slv_low[c] = (byt < 4) && ack_mask[c][byt] && !(rd_mode[c] && byt == 1);
                else if (rd_mode[c] && byt == 1)
                    slv_low[c] = !rd_val[c][7 - pos];
                else
                    slv_low[c] = 1'b0;
            end
            pscl[c] = scl_v[c];
            psda[c] = sda_v[c];
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic host_write(input logic [9:0] a, input logic [7:0] v);
        @(negedge clk);
        adr = a; drv_val = v; drv_en = 1'b1; bwr = 1'b0;
        repeat (3) @(negedge clk);
        bwr = 1'b1;
        repeat (4) @(negedge clk);
        drv_en = 1'b0;
    endtask

    task automatic host_read(input logic [9:0] a, output logic [7:0] v);
        @(negedge clk);
        adr = a; brd = 1'b0;
        #2 v = data;
        @(negedge clk);
        brd = 1'b1;
    endtask

    task automatic wait_done(input int c, input int sbase);
        int n = 0;
        while (stops[c] == sbase && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("stop_timeout", 1, 0);
        repeat (2 * CLK_DIV + 4) @(negedge clk);
    endtask

    task automatic chk_bytes(input int c, input int cb, input int nb, input logic [23:0] eb);
        chk("nbytes", cap_n[c] - cb, nb);
        for (int i = 0; i < nb; i++)
            chk("bus_byte", cap_mem[c][(cb + i) % 64], eb[23 - 8*i -: 8]);
    endtask

    task automatic do_txn(input int c, input logic [7:0] cmd, input logic [3:0] am,
                          input logic [7:0] rv, input int nb, input logic [23:0] eb,
                          input logic [7:0] est);
        int sb, stb, pb, cb;
        logic [7:0] v;
        ack_mask[c] = am; rd_val[c] = rv;
        sb = stops[c]; stb = starts[c]; pb = pulses[c]; cb = cap_n[c];
        host_write(BASE + 10'(4*c), cmd);
        wait_done(c, sb);
        chk("starts", starts[c] - stb, 1);
        chk("stops", stops[c] - sb, 1);
        chk("pulses", pulses[c] - pb, 9 * nb);
        chk_bytes(c, cb, nb, eb);
        host_read(BASE + 10'(4*c), v);
        chk("status", v, est);
    endtask

    typedef struct {
        bit         wr;
        logic [9:0] a;
        logic [7:0] v;
    } vec_t;

    vec_t       vecs [18];
    logic [7:0] rv8;
    int         lat;
    int         sb0, sb3, cb0, cb3, rb;
    logic [7:0] mdl_reg [4];
    logic [7:0] mdl_wd  [4];
    logic [7:0] mdl_rd  [4];

    initial begin
        for (int c = 0; c < 4; c++) begin ack_mask[c] = 4'hF; rd_val[c] = 8'h00; end
        vecs[0]  = '{1, 10'h051, 8'h09};  vecs[1]  = '{1, 10'h052, 8'h20};
        vecs[2]  = '{0, 10'h051, 8'h09};  vecs[3]  = '{0, 10'h052, 8'h20};
        vecs[4]  = '{1, 10'h055, 8'h33};  vecs[5]  = '{1, 10'h05E, 8'h44};
        vecs[6]  = '{0, 10'h055, 8'h33};  vecs[7]  = '{0, 10'h05E, 8'h44};
        vecs[8]  = '{1, 10'h053, 8'h77};  vecs[9]  = '{0, 10'h053, 8'h00};
        vecs[10] = '{0, 10'h050, 8'h00};  vecs[11] = '{0, 10'h000, 8'hFF};
        vecs[12] = '{0, 10'h060, 8'hFF};  vecs[13] = '{0, 10'h04F, 8'hFF};
        vecs[14] = '{0, 10'h059, 8'h00};  vecs[15] = '{1, 10'h060, 8'h99};
        vecs[16] = '{0, 10'h051, 8'h09};  vecs[17] = '{0, 10'h052, 8'h20};

        // Reset and idle state
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        chk("rst_scl", int'(scl_v), 4'hF);
        chk("rst_sda", int'(sda_v), 4'hF);
        chk("rst_data_z", data, 8'hFF);
        host_read(10'h050, rv8); chk("rst_status0", rv8, 8'h00);
        host_read(10'h051, rv8); chk("rst_reg0", rv8, 8'h00);

        // Register window vectors
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) host_write(vecs[i].a, vecs[i].v);
            else begin
                host_read(vecs[i].a, rv8);
                chk($sformatf("vec%0d_rd_%03h", i, vecs[i].a), rv8, vecs[i].v);
            end
        end
        chk("no_scl_activity", rises[0] + rises[1] + rises[2] + rises[3], 0);

        // Write transaction with start latency, busy status, ignored CMD, shadowed REG
        host_write(10'h051, 8'h09);
        host_write(10'h052, 8'h20);
        ack_mask[0] = 4'hF;
        sb0 = stops[0]; cb0 = cap_n[0]; rb = rises[0];
        @(negedge clk);
        adr = 10'h050; drv_val = 8'h7C; drv_en = 1'b1; bwr = 1'b0;
        repeat (3) @(negedge clk);
        bwr = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (sda_v[0] == 1'b0) break;
        end
        drv_en = 1'b0;
        chk("start_latency", lat, 3 + CLK_DIV);
        host_read(10'h050, rv8); chk("busy_status", rv8, 8'h80);
        host_write(10'h050, 8'h42);
        host_write(10'h051, 8'h55);
        wait_done(0, sb0);
        chk("wr_pulses", rises[0] - rb - 1, 27);
        chk_bytes(0, cb0, 3, 24'h7C0920);
        host_read(10'h050, rv8); chk("wr_status_after", rv8, 8'h00);
        chk("other_scl_idle", rises[1] + rises[2] + rises[3], 0);

        // NACK on address byte
        do_txn(0, 8'h7C, 4'h0, 8'h00, 1, 24'h7C0000, 8'h40);

        // Read transaction (folds into a write when read support is compiled out)
`ifdef MAIN_I2C_READ_EN
        do_txn(0, 8'h7D, 4'hF, 8'hA5, 2, 24'h7DA500, 8'h00);
        chk("master_nack_release", last_ack[0], 1);
        host_read(10'h053, rv8); chk("rdata", rv8, 8'hA5);
`else
        do_txn(0, 8'h7D, 4'hF, 8'hA5, 3, 24'h7C5520, 8'h00);
        host_read(10'h053, rv8); chk("rdata_absent", rv8, 8'h00);
`endif

        // Concurrent channels 0 and 3
        host_write(10'h051, 8'h11); host_write(10'h052, 8'h22);
        host_write(10'h05D, 8'h3A); host_write(10'h05E, 8'hC3);
        ack_mask[0] = 4'hF; ack_mask[3] = 4'hF;
        sb0 = stops[0]; cb0 = cap_n[0]; sb3 = stops[3]; cb3 = cap_n[3];
        host_write(10'h050, 8'h30);
        host_write(10'h05C, 8'hA0);
        host_read(10'h050, rv8); chk("conc_busy0", rv8, 8'h80);
        host_read(10'h05C, rv8); chk("conc_busy3", rv8, 8'h80);
        wait_done(0, sb0);
        wait_done(3, sb3);
        chk_bytes(0, cb0, 3, 24'h301122);
        chk_bytes(3, cb3, 3, 24'hA03AC3);

        // Reset in the middle of a transaction releases the lines immediately
        rb = rises[1];
        host_write(10'h054, 8'h5A);
        lat = 0;
        while (rises[1] - rb < 3 && lat < 500) begin @(negedge clk); lat++; end
        if (lat >= 500) chk("midrst_timeout", 1, 0);
        res = 1'b1;
        @(posedge clk); #1;
        chk("midrst_scl", scl_v[1], 1);
        chk("midrst_sda", sda_v[1], 1);
        @(negedge clk);
        res = 1'b0;
        host_read(10'h054, rv8); chk("midrst_status", rv8, 8'h00);
        host_read(10'h051, rv8); chk("midrst_reg", rv8, 8'h00);
        for (int c = 0; c < 4; c++) begin mdl_reg[c] = 0; mdl_wd[c] = 0; mdl_rd[c] = 0; end

        // Randomized transactions against a byte-level model
        for (int it = 0; it < 12; it++) begin
            int c, na, nb;
            logic [7:0] cmd, r, w, rv, eff;
            logic [23:0] eb;
            logic [7:0] est;
            c   = $urandom_range(0, 3);
            na  = $urandom_range(0, 3);
            cmd = 8'($urandom); r = 8'($urandom); w = 8'($urandom); rv = 8'($urandom);
            host_write(BASE + 10'(4*c + 1), r); mdl_reg[c] = r;
            host_write(BASE + 10'(4*c + 2), w); mdl_wd[c] = w;
            host_read(BASE + 10'(4*c + 1), rv8); chk("rnd_reg", rv8, mdl_reg[c]);
            host_read(BASE + 10'(4*c + 2), rv8); chk("rnd_wdata", rv8, mdl_wd[c]);
`ifdef MAIN_I2C_READ_EN
            eff = cmd;
`else
            eff = {cmd[7:1], 1'b0};
`endif
            if (eff[0]) begin
                nb  = (na >= 1) ? 2 : 1;
                est = (na >= 1) ? 8'h00 : 8'h40;
                eb  = {eff, rv, 8'h00};
                if (na >= 1) mdl_rd[c] = rv;
            end else begin
                nb  = (na < 3) ? na + 1 : 3;
                est = (na < 3) ? 8'h40 : 8'h00;
                eb  = {eff, r, w};
            end
            do_txn(c, cmd, 4'((1 << na) - 1), rv, nb, eb, est);
            host_read(BASE + 10'(4*c + 3), rv8); chk("rnd_rdata", rv8, mdl_rd[c]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
